display_scan_ctrl: RTL and testbench

Time-multiplexing controller that sits directly upstream of the seven-segment decoder on the 4-digit display. It captures the two 4-bit operands and computes their sum and difference once per scan frame, then rotates a one-cold anode select across the four digits. Each digit slot begins with a blanking interval to suppress ghosting. All outputs are registered and feed the decoder's `A`, `B`, `AplusB`, `AminusB` and `anode` inputs directly.

---
 rtl/display_pkg.sv | 14 +
 rtl/display_scan_ctrl_if.sv | 16 +
 rtl/slot_timer.sv | 22 ++
 rtl/display_scan_ctrl.sv | 60 ++++++
 tb/tb_display_scan_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared types, anode codes and helpers for the scan controller and decoder.
package display_pkg;
  typedef logic [3:0] nibble_t;
  typedef logic [1:0] digit_t;
  typedef enum logic {BLANK, SHOW} phase_t;
  localparam nibble_t AN_OFF  = 4'b1111;
  localparam nibble_t AN_DIG0 = 4'b1110;
  localparam nibble_t AN_DIG1 = 4'b1101;
  localparam nibble_t AN_DIG2 = 4'b1011;
  localparam nibble_t AN_DIG3 = 4'b0111;
  function automatic nibble_t an_code(digit_t d);
    return d == 2'd0 ? AN_DIG0 : d == 2'd1 ? AN_DIG1 : d == 2'd2 ? AN_DIG2 : AN_DIG3;
  endfunction
endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: operand inputs and registered decoder-facing outputs of the scan controller.
interface display_scan_ctrl_if;
  import display_pkg::*;
  logic en;
  logic hold;
  nibble_t A_in;
  nibble_t B_in;
  nibble_t A;
  nibble_t B;
  nibble_t AplusB;
  nibble_t AminusB;
  nibble_t anode;
  logic frame_done;
  modport master(output en, hold, A_in, B_in, input A, B, AplusB, AminusB, anode, frame_done);
  modport slave(input en, hold, A_in, B_in, output A, B, AplusB, AminusB, anode, frame_done);
endinterface

// File: rtl/slot_timer.sv
// slot_timer: per-digit tick counter with sync clear, flagging end of blanking and end of slot.
module slot_timer #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic [$clog2(DIGIT_TICKS)-1:0] tick,
  output logic blank_end,
  output logic slot_end
);
  localparam int TW = $clog2(DIGIT_TICKS);
  logic [TW-1:0] tick_q, tick_d;
  always_comb begin
    blank_end = tick_q == TW'(BLANK_TICKS - 1);
    slot_end  = tick_q == TW'(DIGIT_TICKS - 1);
    tick_d    = (clr || slot_end) ? '0 : tick_q + 1'b1;
  end
  always_ff @(posedge clk) tick_q <= rst ? '0 : tick_d;
  assign tick = tick_q;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: captures operands once per frame and rotates a blanked one-cold anode scan.
module display_scan_ctrl import display_pkg::*; #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input logic clk,
  input logic rst,
  display_scan_ctrl_if.slave bus
);
  localparam int TW = $clog2(DIGIT_TICKS);
  logic [TW-1:0] tick;
  logic blank_end, slot_end, clr, cap;
  digit_t digit_q, digit_d;
  phase_t phase_q, phase_d;
  nibble_t a_q, a_d, b_q, b_d, sum_q, sum_d, diff_q, diff_d, anode_q, anode_d;
  logic frame_done_q, frame_done_d;
  slot_timer #(.DIGIT_TICKS(DIGIT_TICKS), .BLANK_TICKS(BLANK_TICKS)) u_timer (
    .clk(clk), .rst(rst), .clr(clr), .tick(tick), .blank_end(blank_end), .slot_end(slot_end)
  );
  always_comb begin
    clr          = !bus.en;
    cap          = bus.en && !bus.hold && digit_q == 2'd0 && phase_q == BLANK && tick == '0;
    digit_d      = !bus.en ? 2'd0 : slot_end ? digit_q + 2'd1 : digit_q;
    phase_d      = (!bus.en || slot_end) ? BLANK : blank_end ? SHOW : phase_q;
    a_d          = cap ? bus.A_in : a_q;
    b_d          = cap ? bus.B_in : b_q;
    sum_d        = cap ? bus.A_in + bus.B_in : sum_q;
    diff_d       = cap ? bus.A_in - bus.B_in : diff_q;
    // anode/frame_done describe this cycle's state, so they appear one edge later
    anode_d      = (bus.en && phase_q == SHOW) ? an_code(digit_q) : AN_OFF;
    frame_done_d = bus.en && digit_q == 2'd3 && slot_end;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q      <= 2'd0;
      phase_q      <= BLANK;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      diff_q       <= '0;
      anode_q      <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      phase_q      <= phase_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      diff_q       <= diff_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign bus.A          = a_q;
  assign bus.B          = b_q;
  assign bus.AplusB     = sum_q;
  assign bus.AminusB    = diff_q;
  assign bus.anode      = anode_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed vectors and multi-cycle sequences with DIGIT_TICKS=8, BLANK_TICKS=2.
module tb_display_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  display_scan_ctrl_if bus();
  display_scan_ctrl #(.DIGIT_TICKS(8), .BLANK_TICKS(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic [3:0] diff;
  } vec_t;
  vec_t vecs[6];
  logic [3:0] codes[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_anode(int c);
    if (c == 0 || (c - 1) % 8 < 2) return 4'hF;
    return codes[((c - 1) / 8) % 4];
  endfunction

  always @(negedge clk) begin
    checks++;
    if ($countones(~bus.anode) > 1) begin
      errors++;
      $display("FAIL onecold anode got %b expected at most one low bit", bus.anode);
    end
  end

  initial begin
    codes = '{4'hE, 4'hD, 4'hB, 4'h7};
    vecs[0] = '{4'h3, 4'h5, 4'h8, 4'hE};
    vecs[1] = '{4'hF, 4'h1, 4'h0, 4'hE};
    vecs[2] = '{4'h0, 4'h1, 4'h1, 4'hF};
    vecs[3] = '{4'h7, 4'h7, 4'hE, 4'h0};
    vecs[4] = '{4'h8, 4'h9, 4'h1, 4'hF};
    vecs[5] = '{4'h9, 4'h2, 4'hB, 4'h7};
    bus.en = 1'b1;
    bus.hold = 1'b0;
    bus.A_in = 4'h3;
    bus.B_in = 4'h5;
    step();
    step();
    rst = 1'b0;
    chk("reset_A", bus.A, 4'h0);
    chk("reset_B", bus.B, 4'h0);
    chk("reset_sum", bus.AplusB, 4'h0);
    chk("reset_diff", bus.AminusB, 4'h0);
    chk("reset_anode", bus.anode, 4'hF);
    chk("reset_fd", {3'b0, bus.frame_done}, 4'h0);
    // scan sequence from reset release
    for (int c = 1; c <= 70; c++) begin
      step();
      chk("scan_anode", bus.anode, exp_anode(c));
      chk("scan_fd", {3'b0, bus.frame_done}, (c % 32 == 0) ? 4'h1 : 4'h0);
      if (c == 1) begin
        chk("first_A", bus.A, 4'h3);
        chk("first_B", bus.B, 4'h5);
        chk("first_sum", bus.AplusB, 4'h8);
        chk("first_diff", bus.AminusB, 4'hE);
      end
    end
    // arithmetic vectors, each captured at a fresh frame start
    for (int i = 0; i < 6; i++) begin
      bus.en = 1'b0;
      step();
      chk("vec_off_anode", bus.anode, 4'hF);
      bus.A_in = vecs[i].a;
      bus.B_in = vecs[i].b;
      bus.en = 1'b1;
      step();
      chk("vec_A", bus.A, vecs[i].a);
      chk("vec_B", bus.B, vecs[i].b);
      chk("vec_sum", bus.AplusB, vecs[i].sum);
      chk("vec_diff", bus.AminusB, vecs[i].diff);
    end
    // operand change during digit 2 waits for next frame
    bus.en = 1'b0;
    step();
    bus.A_in = 4'h2;
    bus.B_in = 4'h1;
    bus.en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 20) bus.A_in = 4'h9;
      if (k == 25 || k == 32) chk("midframe_A", bus.A, 4'h2);
    end
    step();
    chk("newframe_A", bus.A, 4'h9);
    chk("newframe_sum", bus.AplusB, 4'hA);
    // hold across frame boundary (now at frame cycle 33)
    bus.hold = 1'b1;
    bus.A_in = 4'h4;
    bus.B_in = 4'h4;
    for (int k = 34; k <= 67; k++) begin
      step();
      if (k == 64) chk("hold_fd", {3'b0, bus.frame_done}, 4'h1);
      if (k == 66) chk("hold_A", bus.A, 4'h9);
      if (k == 66) chk("hold_B", bus.B, 4'h1);
      if (k == 67) chk("hold_anode", bus.anode, 4'hE);
    end
    bus.hold = 1'b0;
    for (int k = 68; k <= 97; k++) begin
      step();
      if (k == 96) chk("unhold_pre_A", bus.A, 4'h9);
    end
    chk("unhold_A", bus.A, 4'h4);
    chk("unhold_sum", bus.AplusB, 4'h8);
    chk("unhold_diff", bus.AminusB, 4'h0);
    // drop en during digit 3 SHOW (frame cycle 28)
    for (int k = 98; k <= 124; k++) step();
    chk("d3_anode", bus.anode, 4'h7);
    bus.en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("off_anode", bus.anode, 4'hF);
      chk("off_fd", {3'b0, bus.frame_done}, 4'h0);
    end
    chk("off_A", bus.A, 4'h4);
    bus.A_in = 4'h6;
    bus.B_in = 4'h2;
    bus.en = 1'b1;
    step();
    chk("reen_A", bus.A, 4'h6);
    chk("reen_diff", bus.AminusB, 4'h4);
    chk("reen_anode1", bus.anode, 4'hF);
    step();
    chk("reen_anode2", bus.anode, 4'hF);
    step();
    chk("reen_anode3", bus.anode, 4'hE);
    // reset mid-SHOW of digit 1 (frame cycle 12)
    for (int k = 4; k <= 12; k++) step();
    chk("d1_anode", bus.anode, 4'hD);
    rst = 1'b1;
    step();
    chk("rst_A", bus.A, 4'h0);
    chk("rst_B", bus.B, 4'h0);
    chk("rst_sum", bus.AplusB, 4'h0);
    chk("rst_diff", bus.AminusB, 4'h0);
    chk("rst_anode", bus.anode, 4'hF);
    chk("rst_fd", {3'b0, bus.frame_done}, 4'h0);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("rescan_anode", bus.anode, exp_anode(c));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
